hilo_ctrl: RTL
==============

# hilo_ctrl

Multi-cycle multiply/divide sequencer that owns the write side of the HI and LO registers. It accepts one operation at a time from the EX stage, runs an iterative 32-step shift-add multiply or shift-subtract divide, and drives the HI/LO data and enable inputs. It also raises a pipeline stall while busy so that mfhi/mflo and new HI/LO ops never see a stale or partial result.

## Interface
- DATA_W, 32, operand and HI/LO width; the iteration count equals DATA_W.
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  request strobe; sampled only in IDLE.
- Op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB.
- A  in  DATA_W  rs operand.
- B  in  DATA_W  rt operand.
- HIcur  in  DATA_W  current HI register value; used by MADD/MSUB.
- LOcur  in  DATA_W  current LO register value; used by MADD/MSUB.
- ReadReq  in  1  ID stage holds mfhi/mflo.
- HIin  out  DATA_W  registered data to HI.
- LOin  out  DATA_W  registered data to LO.
- HIen  out  1  registered HI write enable, one-cycle pulse.
- LOen  out  1  registered LO write enable, one-cycle pulse.
- Busy  out  1  high whenever state != IDLE.
- Stall  out  1  combinational: Busy & (ReadReq | Start).
- Done  out  1  one-cycle pulse, coincident with HIen/LOen.

## Operation
- States: IDLE, CALC, FIXUP, WRITE.
- IDLE + Start latches Op, A, B, HIcur and LOcur, then branches:
  - MTHI/MTLO -> WRITE.
  - DIV/DIVU with B==0 -> WRITE.
  - All other ops -> CALC.
- CALC: DATA_W iterations on unsigned magnitudes, counter 0..DATA_W-1.
  - Multiply: 64-bit product register, shift-add.
  - Divide: restoring shift-subtract; quotient in the low half, remainder in the high half.
- FIXUP (one cycle):
  - Signed ops negate results as needed. Product sign is sA^sB. Quotient sign is sA^sB; remainder sign is sA.
  - MADD adds {HIcur,LOcur} to the signed product; MSUB subtracts it. All 64-bit arithmetic is mod 2^64.
- WRITE (one cycle) drives HIin/LOin and the enables, pulses Done, then returns to IDLE.
  - MULT/DIV/MADD/MSUB: HIen=LOen=1.
  - MTHI: HIen=1 only, HIin=A.
  - MTLO: LOen=1 only, LOin=A.
- Divide by zero writes HI=A and LO=0xFFFFFFFF.
- DIV 0x80000000 / -1 writes LO=0x80000000, HI=0. This falls out of magnitude arithmetic with 32-bit wrap.
- Start while Busy is ignored. The pipeline is frozen by Stall and re-presents the request.
- Reset values: state IDLE, HIin=LOin=0, HIen=LOen=Done=Busy=0, counter 0.

## Timing
- Start is sampled at edge 0. Cycle n means the n-th cycle after that edge.
- MTHI/MTLO/divide-by-zero: WRITE in cycle 1, latency 1.
- MULT/MULTU/DIV/DIVU/MADD/MSUB: CALC in cycles 1..32, FIXUP in cycle 33, WRITE in cycle 34.
- The HI/LO registers capture at the end of the WRITE cycle.
- Busy is high from cycle 1 through the WRITE cycle inclusive.
- A new Start is accepted in the cycle after WRITE (back-to-back; no dead cycle beyond IDLE).
- ReadReq during the WRITE cycle still stalls. mfhi/mflo proceeds the following cycle and sees the new values.
- Rst asserted in any state takes effect at the next edge.
  - No HIen/LOen/Done is produced for the aborted op.
  - The block is in IDLE and accepts Start on the cycle after Rst deasserts.

## Structure
- Shared package hilo_pkg holds:
  - DATA_W default.
  - op_t enum (3-bit codes above).
  - state_t enum (IDLE, CALC, FIXUP, WRITE).
  - DIV0_LO constant 0xFFFFFFFF.
- One sub-module, muldiv_iter_core: the 64-bit shift register, counter and add/subtract step, with a mul/div select, a load strobe and a done flag.
- hilo_ctrl keeps the FSM, operand latching, sign fix-up, accumulate and output registers.

## Test plan
- MULT A=0xFFFFFFFD (-3), B=7 -> cycle 34: HIen=LOen=Done=1, HIin=0xFFFFFFFF, LOin=0xFFFFFFEB; Busy low in cycle 35.
- DIV A=0xFFFFFFF9 (-7), B=2 -> cycle 34: LOin=0xFFFFFFFD, HIin=0xFFFFFFFF. DIVU A=100, B=7 -> LOin=14, HIin=2.
- DIVU A=7, B=0 -> cycle 1: HIin=7, LOin=0xFFFFFFFF, both enables high. DIV A=0x80000000, B=0xFFFFFFFF -> LOin=0x80000000, HIin=0.
- MADD HIcur=0, LOcur=0xFFFFFFFF, A=1, B=1 -> HIin=1, LOin=0. MSUB with the same operands and HIcur=1, LOcur=0 -> HIin=0, LOin=0xFFFFFFFF.
- MTLO A=0x1234 -> cycle 1: LOen=1, HIen=0, LOin=0x1234.
- MULTU in progress:
  - ReadReq=1 at cycle 5 -> Stall=1.
  - Start with a different Op at cycle 5 -> ignored; the result matches the original op.
- DIV started, Rst at cycle 10 -> no enables or Done ever pulse; Busy=0 after the reset edge. A following MTHI A=5 writes HIin=5 one cycle after its Start.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package hilo_pkg;

    localparam int DATA_W = 32;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MSUB  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        WRITE = 2'd3
    } state_t;

    // Ops whose operands are two's complement and need sign fix-up.
    function automatic logic is_signed(input op_t op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
module muldiv_iter_core #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           is_div,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] acc,
    output logic           done
);
    localparam int CW = $clog2(W);

    logic [CW-1:0] cnt;
    logic          run;
    logic          div_q;
    logic [W-1:0]  b_q;
    logic [W:0]    sum;
    logic [W:0]    diff;
    logic [2*W-1:0] step;

    // Divide keeps the partial remainder in the upper half; diff[W] is the borrow.
    always_comb begin
        sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_q} : {(W+1){1'b0}});
        diff = acc[2*W-1:W-1] - {1'b0, b_q};
        if (div_q)
            step = diff[W] ? {acc[2*W-2:0], 1'b0} : {diff[W-1:0], acc[W-2:0], 1'b1};
        else
            step = {sum, acc[W-1:1]};
    end

    assign done = run && (cnt == CW'(W-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            run   <= 1'b0;
            div_q <= 1'b0;
            b_q   <= '0;
        end else if (load) begin
            acc   <= {{W{1'b0}}, a};
            b_q   <= b;
            div_q <= is_div;
            cnt   <= '0;
            run   <= 1'b1;
        end else if (run) begin
            acc <= step;
            if (done) run <= 1'b0;
            else      cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/hilo_ctrl.sv
// Multi-cycle MULT/DIV/MADD/MSUB/MTHI/MTLO sequencer driving the HI/LO write port.
module hilo_ctrl #(
    parameter int DATA_W = hilo_pkg::DATA_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] HIcur,
    input  logic [DATA_W-1:0] LOcur,
    input  logic              ReadReq,
    output logic [DATA_W-1:0] HIin,
    output logic [DATA_W-1:0] LOin,
    output logic              HIen,
    output logic              LOen,
    output logic              Busy,
    output logic              Stall,
    output logic              Done
);
    import hilo_pkg::*;

    state_t state, state_nxt;
    op_t    op_in, op_q;
    logic [DATA_W-1:0] a_q, b_q, hic_q, loc_q;
    logic [DATA_W-1:0] mag_a, mag_b, hi_nxt, lo_nxt;
    logic [2*DATA_W-1:0] acc, prod_s, base, res;
    logic sgn_in, is_div_in, load, core_done, sa, sb, wr_hi, wr_lo;

    assign op_in     = op_t'(Op);
    assign sgn_in    = is_signed(op_in);
    assign is_div_in = (op_in == OP_DIV) || (op_in == OP_DIVU);
    assign mag_a     = (sgn_in && A[DATA_W-1]) ? -A : A;
    assign mag_b     = (sgn_in && B[DATA_W-1]) ? -B : B;

    muldiv_iter_core #(.W(DATA_W)) u_core (
        .clk    (Clk),
        .rst    (Rst),
        .load   (load),
        .is_div (is_div_in),
        .a      (mag_a),
        .b      (mag_b),
        .acc    (acc),
        .done   (core_done)
    );

    // Sign restore and accumulate, evaluated during FIXUP.
    always_comb begin
        sa     = is_signed(op_q) & a_q[DATA_W-1];
        sb     = is_signed(op_q) & b_q[DATA_W-1];
        base   = {hic_q, loc_q};
        prod_s = (sa ^ sb) ? -acc : acc;
        res    = prod_s;
        case (op_q)
            OP_MADD: res = base + prod_s;
            OP_MSUB: res = base - prod_s;
            OP_DIV, OP_DIVU: begin
                res[2*DATA_W-1:DATA_W] = sa ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
                res[DATA_W-1:0]        = (sa ^ sb) ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        hi_nxt    = HIin;
        lo_nxt    = LOin;
        case (state)
            IDLE: if (Start) begin
                if (op_in == OP_MTHI) begin
                    wr_hi = 1'b1; hi_nxt = A; state_nxt = WRITE;
                end else if (op_in == OP_MTLO) begin
                    wr_lo = 1'b1; lo_nxt = A; state_nxt = WRITE;
                end else if (is_div_in && (B == '0)) begin
                    wr_hi = 1'b1; wr_lo = 1'b1;
                    hi_nxt = A; lo_nxt = DIV0_LO;
                    state_nxt = WRITE;
                end else begin
                    load = 1'b1; state_nxt = CALC;
                end
            end
            CALC:  if (core_done) state_nxt = FIXUP;
            FIXUP: begin
                wr_hi  = 1'b1;
                wr_lo  = 1'b1;
                hi_nxt = res[2*DATA_W-1:DATA_W];
                lo_nxt = res[DATA_W-1:0];
                state_nxt = WRITE;
            end
            WRITE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            HIin  <= '0;
            LOin  <= '0;
            HIen  <= 1'b0;
            LOen  <= 1'b0;
            Done  <= 1'b0;
            op_q  <= OP_MULT;
            a_q   <= '0;
            b_q   <= '0;
            hic_q <= '0;
            loc_q <= '0;
        end else begin
            state <= state_nxt;
            HIin  <= hi_nxt;
            LOin  <= lo_nxt;
            HIen  <= wr_hi;
            LOen  <= wr_lo;
            Done  <= wr_hi | wr_lo;
            if (state == IDLE && Start) begin
                op_q  <= op_in;
                a_q   <= A;
                b_q   <= B;
                hic_q <= HIcur;
                loc_q <= LOcur;
            end
        end
    end

    assign Busy  = (state != IDLE);
    assign Stall = Busy & (ReadReq | Start);

endmodule
